// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width
// and the iteration counter width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it did not go negative.
module div_step #(
  parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] dvs_ext;

  assign trial   = {rem_in, dvd_bit};
  assign dvs_ext = {2'b00, divisor};
  assign q_bit   = (trial >= dvs_ext);
  assign rem_out = q_bit ? (WIDTH+1)'(trial - dvs_ext) : trial[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             Signed,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic               accept;
  logic               run_last;
  logic [WIDTH-1:0]   dvd_q, dvs_q;
  logic [WIDTH:0]     rem_q, rem_next;
  logic               q_bit;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_quot_q, neg_rem_q, neg_quot_d, neg_rem_d;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;

  // Start is a request sampled only outside RUN; Busy is high for the WIDTH+1
  // RUN cycles after acceptance; Done is a single-cycle pulse with results valid.
  assign accept    = Start && (state_q != RUN);
  assign run_last  = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH));
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    dvd_mag    = Dividend;
    dvs_mag    = Divisor;
    neg_quot_d = 1'b0;
    neg_rem_d  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (Signed) begin
      if (Dividend[WIDTH-1]) dvd_mag = -Dividend;
      if (Divisor[WIDTH-1])  dvs_mag = -Divisor;
      neg_rem_d  = Dividend[WIDTH-1];
      neg_quot_d = (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]) && (Divisor != '0);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH)) state_d = DONE;
      DONE:    state_d = Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      Quotient   <= '0;
      Remainder  <= '0;
      DivByZero  <= 1'b0;
    end else if (accept) begin
      dvd_q      <= dvd_mag;
      dvs_q      <= dvs_mag;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end else if (run_last) begin
      Quotient  <= neg_quot_q ? -dvd_q : dvd_q;
      Remainder <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      DivByZero <= (dvs_q == '0);
    end else if (state_q == RUN) begin
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      rem_q <= rem_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider; signed cases are built in when
// SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         signed_op = 1'b0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Quotient, Remainder;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rem_q[$];
  logic         exp_dbz_q[$];
  int           exp_cyc_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .Signed    (signed_op),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference model: plain integer division, 64-bit to avoid signed overflow
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic dbz);
    longint sa, sb;
    dbz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_div(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sgn, input int acc_cyc);
    logic [W-1:0] q, r;
    logic d;
    ref_div(a, b, sgn, q, r, d);
    exp_q.push_back(q);
    exp_rem_q.push_back(r);
    exp_dbz_q.push_back(d);
    exp_cyc_q.push_back(acc_cyc + W + 1);
  endtask

  // driver: one-cycle Start pulse, expectation pushed at the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input bit push);
    int c;
    @(negedge CLK);
    Dividend  = a;
    Divisor   = b;
    signed_op = sgn;
    Start     = 1'b1;
    @(posedge CLK);
    #1;
    c     = cyc;
    Start = 1'b0;
    chk("busy_after_accept", W'(Busy), W'(1));
    if (push) expect_div(a, b, sgn, c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_rem_q.delete();
      exp_dbz_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // scoreboard monitor
  logic [W-1:0] mon_q, mon_r;
  logic         mon_d;
  int           mon_c;
  always @(negedge CLK) begin
    if (RST_N && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done at cycle %0d expected none", cyc);
      end else begin
        mon_q = exp_q.pop_front();
        mon_r = exp_rem_q.pop_front();
        mon_d = exp_dbz_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        chk("quotient", Quotient, mon_q);
        chk("remainder", Remainder, mon_r);
        chk("div_by_zero", W'(DivByZero), W'(mon_d));
        chk("done_cycle", W'(cyc), W'(mon_c));
        chk("busy_in_done", W'(Busy), '0);
      end
    end
  end

  initial begin
    int c;
    logic [W-1:0] a, b;

    repeat (3) @(negedge CLK);
    chk("reset_busy", W'(Busy), '0);
    chk("reset_done", W'(Done), '0);
    chk("reset_quotient", Quotient, '0);
    chk("reset_remainder", Remainder, '0);
    chk("reset_dbz", W'(DivByZero), '0);

    // release reset and request on the very next edge
    @(posedge CLK);
    #1 RST_N = 1'b1;
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(32'h1234, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // Start held through RUN with changing operands, then accepted again in DONE
    @(negedge CLK);
    Dividend  = 32'd1000;
    Divisor   = 32'd9;
    signed_op = 1'b0;
    Start     = 1'b1;
    @(posedge CLK);
    #1;
    c = cyc;
    chk("busy_b2b_first", W'(Busy), W'(1));
    expect_div(32'd1000, 32'd9, 1'b0, c);
    repeat (W + 1) begin
      @(negedge CLK);
      Dividend = $urandom;
      Divisor  = $urandom;
    end
    @(negedge CLK);
    Dividend = 32'd77777;
    Divisor  = 32'd123;
    @(posedge CLK);
    #1;
    c     = cyc;
    Start = 1'b0;
    chk("busy_b2b_second", W'(Busy), W'(1));
    expect_div(32'd77777, 32'd123, 1'b0, c);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = $urandom | 32'h8000_0000;
      endcase
      issue(a, b, 1'b0, 1'b1);
      wait_idle();
    end

    // reset during RUN abandons the division and clears outputs at once
    issue(32'd1000, 32'd3, 1'b0, 1'b1);
    wait_idle();
    issue(32'hDEAD, 32'd3, 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrun_reset_busy", W'(Busy), '0);
    chk("midrun_reset_done", W'(Done), '0);
    chk("midrun_reset_quotient", Quotient, '0);
    chk("midrun_reset_remainder", Remainder, '0);
    chk("midrun_reset_dbz", W'(DivByZero), '0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    issue(32'd20, 32'd4, 1'b0, 1'b1);
    wait_idle();

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(a, b, 1'b1, 1'b1);
      wait_idle();
    end
`endif

    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: request a division; sampled only in IDLE and DONE.
REQ-005 SHALL have port Dividend, input, WIDTH bits: numerator; captured on the accepting edge.
REQ-006 SHALL have port Divisor, input, WIDTH bits: denominator; captured on the accepting edge.
REQ-007 SHALL have port Busy, output, 1 bit: high while a division is in progress.
REQ-008 SHALL have port Done, output, 1 bit: one-cycle pulse when the results become valid.
REQ-009 SHALL have port Quotient, output, WIDTH bits: result quotient.
REQ-010 SHALL have port Remainder, output, WIDTH bits: result remainder.
REQ-011 SHALL have port DivByZero, output, 1 bit: flag indicating the last division had Divisor == 0.

Function
REQ-012 SHALL be a restoring shift-subtract divider producing one quotient bit per cycle.
REQ-013 SHALL have three states: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE, move to RUN when Start=1 at the edge: capture operands, clear the iteration counter, assert Busy from that edge.
REQ-015 SHALL stay in RUN for exactly WIDTH edges, then move to DONE, making Done=1 and Busy=0 for one cycle.
REQ-016 SHALL therefore assert Done WIDTH+1 edges after the accepting edge (WIDTH=32: 33 cycles).
REQ-017 SHALL, in DONE, move to RUN if Start=1 (back-to-back accept, Busy rises at that edge); otherwise move to IDLE.
REQ-018 SHALL ignore Start in RUN; no restart and no operand recapture occur.
REQ-019 SHALL update Quotient, Remainder and DivByZero only on the edge entering DONE, and hold them until the next DONE.
REQ-020 SHALL, when Divisor == 0, take the full latency and produce Quotient = all ones, Remainder = Dividend, DivByZero = 1.
REQ-021 SHALL, for Divisor != 0, produce DivByZero = 0 and satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor (unsigned).
REQ-022 SHALL keep the internal partial remainder WIDTH+1 bits wide, so that Divisor >= 2^(WIDTH-1) causes no overflow.

Reset
REQ-023 SHALL, when RST_N=0, immediately force IDLE regardless of CLK, including mid-RUN, abandoning any division in progress.
REQ-024 SHALL, during reset, drive Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, and clear the internal counter and operand registers.
REQ-025 SHALL accept Start on the first rising edge after RST_N deasserts.

Configuration
REQ-026 SHALL support signed division when macro SEQ_DIVIDER_SIGNED_EN is defined, adding input port Signed (1 bit, captured with the operands).
REQ-027 SHALL, with SEQ_DIVIDER_SIGNED_EN defined and Signed=1:
- divide operand magnitudes;
- truncate the quotient toward zero;
- give the remainder the sign of Dividend;
- keep the latency unchanged;
- for divide-by-zero, give Quotient = all ones and Remainder = Dividend;
- for the most-negative value / -1, give Quotient = most-negative value and Remainder = 0.
REQ-028 SHALL, without SEQ_DIVIDER_SIGNED_EN, have no Signed port and perform unsigned division only.

Structure
REQ-029 SHALL take the state encoding (IDLE/RUN/DONE), the default WIDTH and the counter width (clog2(WIDTH)+1) from shared package div_pkg.
REQ-030 SHALL place one restoring iteration (shift, trial subtract, select, quotient bit) in combinational sub-module div_step, instantiated once.

Verification
REQ-031 SHALL cover: Dividend=100, Divisor=7, Start pulse -> Done exactly 33 cycles later, Quotient=14, Remainder=2, DivByZero=0.
REQ-032 SHALL cover: Dividend=0xFFFFFFFF, Divisor=0x80000000 -> Quotient=1, Remainder=0x7FFFFFFF.
REQ-033 SHALL cover: Divisor=0, Dividend=0x1234 -> Quotient=0xFFFFFFFF, Remainder=0x1234, DivByZero=1 after 33 cycles.
REQ-034 SHALL cover: Start held high through RUN with changing operands -> first result unaffected; Start=1 in the DONE cycle -> second division accepted with no idle gap.
REQ-035 SHALL cover: RST_N pulsed low at cycle 10 of RUN -> outputs zero immediately, no Done; a new 20/4 division then gives Quotient=5, Remainder=0.
REQ-036 SHALL cover, with SEQ_DIVIDER_SIGNED_EN: Signed=1, -7 / 2 -> Quotient=-3, Remainder=-1; 0x80000000 / -1 -> Quotient=0x80000000, Remainder=0.
